// File: rtl/int_to_fp_pkg.sv
// Shared widths, result encoding and FSM state type for the integer-to-float converter.
package int_to_fp_pkg;

  localparam int unsigned INT_W  = 8;
  localparam int unsigned EXP_W  = 4;
  localparam int unsigned FRAC_W = 8;
  localparam int unsigned FP_W   = 1 + EXP_W + FRAC_W;

  // value = (-1)^sign * 0.frac * 2^exp
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_t;

  localparam fp_t ZERO_ENC = '{sign: 1'b0, exp: '0, frac: '0};

  // Exponent loaded before normalization; the magnitude is read as 0.frac * 2^8.
  localparam logic [EXP_W-1:0] EXP_MAX_NORM = EXP_W'(INT_W);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StNorm = 2'd1,
    StDone = 2'd2
  } state_e;

  // Two's-complement magnitude; -2^(INT_W-1) maps to 2^(INT_W-1) as an unsigned value.
  function automatic logic [FRAC_W-1:0] abs_mag(input logic [INT_W-1:0] v);
    return v[INT_W-1] ? FRAC_W'(~v + 1'b1) : FRAC_W'(v);
  endfunction

endpackage

// File: rtl/int_to_fp.sv
// Sequential signed-integer to {sign, exp, frac} converter; normalizes with one
// left shift per clock and asserts done_tick for a single cycle when finished.
module int_to_fp
  import int_to_fp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [INT_W-1:0]  integ,
  output logic              ready,
  output logic              done_tick,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [FRAC_W-1:0] frac
);

  state_e state_q, state_d;
  fp_t    fp_q, fp_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      fp_q    <= ZERO_ENC;
    end else begin
      state_q <= state_d;
      fp_q    <= fp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fp_d    = fp_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (integ == '0) begin
            fp_d    = ZERO_ENC;
            state_d = StDone;
          end else begin
            fp_d.sign = integ[INT_W-1];
            fp_d.frac = abs_mag(integ);
            fp_d.exp  = EXP_MAX_NORM;
            state_d   = StNorm;
          end
        end
      end
      StNorm: begin
        // A nonzero magnitude reaches frac[MSB] in at most INT_W-1 shifts, so exp stays >= 1.
        if (fp_q.frac[FRAC_W-1]) begin
          state_d = StDone;
        end else begin
          fp_d.frac = {fp_q.frac[FRAC_W-2:0], 1'b0};
          fp_d.exp  = fp_q.exp - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign ready     = (state_q == StIdle);
  assign done_tick = (state_q == StDone);
  assign sign      = fp_q.sign;
  assign exp       = fp_q.exp;
  assign frac      = fp_q.frac;

endmodule

// File: tb/tb_int_to_fp.sv
// Self-checking bench for int_to_fp: directed cases, random operands and an
// exhaustive round trip through a behavioural float-to-integer model.
module tb_int_to_fp;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] integ;
  logic       ready;
  logic       done_tick;
  logic       sign;
  logic [3:0] exp;
  logic [7:0] frac;

  int total = 0;
  int bad   = 0;

  int_to_fp dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .integ     (integ),
    .ready     (ready),
    .done_tick (done_tick),
    .sign      (sign),
    .exp       (exp),
    .frac      (frac)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference encoding from the value itself: exp is the bit length of |v|.
  function automatic logic [12:0] ref_fp(input int v);
    int mag;
    int e;
    int f;
    if (v == 0) return 13'd0;
    mag = (v < 0) ? -v : v;
    e   = $clog2(mag + 1);
    f   = mag * (2 ** (8 - e));
    return {(v < 0) ? 1'b1 : 1'b0, 4'(e), 8'(f)};
  endfunction

  function automatic int ref_edges(input int v);
    int mag;
    if (v == 0) return 1;
    mag = (v < 0) ? -v : v;
    return 10 - $clog2(mag + 1);
  endfunction

  // Behavioural float-to-integer: value = frac * 2^(exp-8); returns {uf, of} flags too.
  task automatic fp_to_int_model(input logic s, input logic [3:0] e, input logic [7:0] f,
                                 output int val, output logic [1:0] flags);
    int mag;
    flags = 2'b00;
    if (f == 0) begin
      val = 0;
      return;
    end
    if (e == 0) flags[1] = 1'b1;
    if (e > 8) flags[0] = 1'b1;
    mag = (e <= 8) ? (int'(f) / (2 ** (8 - e))) : 0;
    val = s ? -mag : mag;
    if (s ? (mag > 128) : (mag > 127)) flags[0] = 1'b1;
  endtask

  // Pulses start in IDLE, counts edges up to done_tick, then steps into the next IDLE cycle.
  task automatic convert(input logic [7:0] v, output int edges, output logic rdy_low,
                         output logic one_pulse);
    edges   = 0;
    rdy_low = 1'b1;
    @(negedge clk);
    start = 1'b1;
    integ = v;
    @(posedge clk);
    edges = 1;
    #1;
    start = 1'b0;
    while (!done_tick && edges < 20) begin
      if (ready) rdy_low = 1'b0;
      @(posedge clk);
      edges++;
      #1;
    end
    if (ready) rdy_low = 1'b0;
    if (!done_tick) chk("timeout", 32'(edges), 32'(ref_edges(int'($signed(v)))));
    @(posedge clk);
    #1;
    one_pulse = !done_tick && ready;
  endtask

  initial begin
    int         edges;
    logic       rl;
    logic       op;
    int         back;
    logic [1:0] flags;
    int         dones;
    int         v;

    reset = 1'b1;
    start = 1'b0;
    integ = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_done", 32'(done_tick), 32'd0);
    chk("reset_fp", 32'({sign, exp, frac}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    convert(8'h01, edges, rl, op);
    chk("p1_fp", 32'({sign, exp, frac}), 32'({1'b0, 4'd1, 8'h80}));
    chk("p1_edges", 32'(edges), 32'd9);
    chk("p1_ready_low", 32'(rl), 32'd1);
    chk("p1_one_pulse", 32'(op), 32'd1);

    convert(8'h7F, edges, rl, op);
    chk("p127_fp", 32'({sign, exp, frac}), 32'({1'b0, 4'd7, 8'hFE}));
    chk("p127_edges", 32'(edges), 32'd3);

    convert(8'h80, edges, rl, op);
    chk("m128_fp", 32'({sign, exp, frac}), 32'({1'b1, 4'd8, 8'h80}));
    chk("m128_edges", 32'(edges), 32'd2);

    convert(8'hFF, edges, rl, op);
    chk("m1_fp", 32'({sign, exp, frac}), 32'({1'b1, 4'd1, 8'h80}));
    chk("m1_edges", 32'(edges), 32'd9);

    convert(8'h00, edges, rl, op);
    chk("zero_fp", 32'({sign, exp, frac}), 32'd0);
    chk("zero_edges", 32'(edges), 32'd1);
    chk("zero_one_pulse", 32'(op), 32'd1);

    // Results hold through idle cycles.
    convert(8'hC3, edges, rl, op);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_fp", 32'({sign, exp, frac}), 32'(ref_fp(-61)));

    // Second start while busy is ignored.
    @(negedge clk);
    start = 1'b1;
    integ = 8'h03;
    @(negedge clk);
    integ = 8'h40;
    @(negedge clk);
    start = 1'b0;
    edges = 2;
    @(posedge clk);
    edges++;
    #1;
    while (!done_tick && edges < 20) begin
      @(posedge clk);
      edges++;
      #1;
    end
    chk("busy_fp", 32'({sign, exp, frac}), 32'({1'b0, 4'd2, 8'hC0}));
    chk("busy_edges", 32'(edges), 32'd8);
    @(posedge clk);
    #1;
    chk("busy_after_done", 32'(done_tick), 32'd0);

    // Reset during NORM aborts with no done_tick.
    @(negedge clk);
    start = 1'b1;
    integ = 8'h05;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_fp", 32'({sign, exp, frac}), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done_tick) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    integ = 8'h11;
    @(posedge clk);
    #1;
    chk("prio_ready", 32'(ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("prio_idle", 32'({ready, done_tick}), 32'b10);

    repeat (40) begin
      v = int'($signed(8'($urandom_range(0, 255))));
      convert(8'(v), edges, rl, op);
      chk($sformatf("rand_fp_%0d", v), 32'({sign, exp, frac}), 32'(ref_fp(v)));
      chk($sformatf("rand_edges_%0d", v), 32'(edges), 32'(ref_edges(v)));
    end

    for (int i = -127; i <= 127; i++) begin
      if (i == 0) continue;
      convert(8'(i), edges, rl, op);
      fp_to_int_model(sign, exp, frac, back, flags);
      chk($sformatf("rt_val_%0d", i), 32'(back), 32'(i));
      chk($sformatf("rt_flags_%0d", i), 32'(flags), 32'd0);
      chk($sformatf("rt_norm_%0d", i), 32'(frac[7]), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
